// File: rtl/life_run_ctrl_pkg.sv
// Shared types and helpers for the cellular-automaton run controller.
package life_ctrl_pkg;

  localparam int CTRL_STATE_W = 3;

  typedef enum logic [CTRL_STATE_W-1:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

  // True for the five encodings the FSM can legitimately hold.
  function automatic logic state_is_legal(input logic [CTRL_STATE_W-1:0] s);
    return (s <= 3'd4);
  endfunction

endpackage

// File: rtl/life_run_ctrl_if.sv
// Control/status bundle between user inputs, the run controller and the grid datapath.
interface life_run_ctrl_if
  import life_ctrl_pkg::*;
#(
  parameter int GEN_W = 16,
  parameter int DIV_W = 24
) ();

  logic                    start;
  logic                    pause;
  logic                    step;
  logic                    load;
  logic [DIV_W-1:0]        div_sel;
  logic [GEN_W-1:0]        gen_limit;
  logic                    grid_rst;
  logic                    seed_we;
  logic                    grid_en;
  logic [GEN_W-1:0]        gen_count;
  logic                    done;
  logic [CTRL_STATE_W-1:0] state_o;

  // Side that drives the user controls and observes the controller.
  modport master (
    output start, pause, step, load, div_sel, gen_limit,
    input  grid_rst, seed_we, grid_en, gen_count, done, state_o
  );

  // The run controller itself.
  modport slave (
    input  start, pause, step, load, div_sel, gen_limit,
    output grid_rst, seed_we, grid_en, gen_count, done, state_o
  );

endinterface

// File: rtl/life_run_ctrl_edge_rise.sv
// Rising-edge detector: one history flop, combinational pulse output.
// A level already high when reset releases produces one edge.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic q_r;

  // Remember last cycle's level of the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= 1'b0;
    end else begin
      q_r <= din;
    end
  end

  assign rise = din & ~q_r;

endmodule

// File: rtl/life_run_ctrl.sv
// Run controller for the life grid: IDLE -> SEED -> RUN/PAUSE -> DONE with
// programmable generation rate, pause, single step and a generation limit.
module life_run_ctrl
  import life_ctrl_pkg::*;
#(
  parameter int GEN_W = 16,
  parameter int DIV_W = 24
) (
  input logic            clk,
  input logic            reset,
  life_run_ctrl_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [GEN_W-1:0] GEN_ZERO = {GEN_W{1'b0}};
  localparam logic [GEN_W-1:0] GEN_ONE  = {{(GEN_W-1){1'b0}}, 1'b1};

  ctrl_state_t      state_r, state_n;
  logic [DIV_W-1:0] presc_r, presc_n;
  logic [GEN_W-1:0] gen_r, gen_n;

  logic             rise_start_s, rise_pause_s, rise_step_s;
  logic             start_go_s;
  logic [DIV_W-1:0] div_last_s;
  logic             tick_s, over_s;
  logic [GEN_W-1:0] gen_inc_s;
  logic             hit_limit_s;
  logic             grid_en_s, grid_rst_s, seed_we_s, done_s;

  edge_rise u_edge_start (.clk(clk), .reset(reset), .din(bus.start), .rise(rise_start_s));
  edge_rise u_edge_pause (.clk(clk), .reset(reset), .din(bus.pause), .rise(rise_pause_s));
  edge_rise u_edge_step  (.clk(clk), .reset(reset), .din(bus.step),  .rise(rise_step_s));

  // A reseed request only counts when the grid is not mid-load.
  assign start_go_s = rise_start_s & ~bus.load;

  // Prescaler terminal value; a zero rate is treated as one clock per generation.
  // over_s catches a rate lowered below the current count: wrap without a pulse.
  assign div_last_s  = (bus.div_sel == DIV_ZERO) ? DIV_ZERO : (bus.div_sel - DIV_ONE);
  assign tick_s      = (presc_r == div_last_s);
  assign over_s      = (presc_r > div_last_s);

  // Limit hits when the pulse about to be issued lands exactly on gen_limit.
  assign gen_inc_s   = gen_r + GEN_ONE;
  assign hit_limit_s = (bus.gen_limit != GEN_ZERO) && (gen_inc_s == bus.gen_limit);

  // Next-state, prescaler, generation counter and advance pulse.
  always_comb begin
    state_n   = state_r;
    presc_n   = presc_r;
    gen_n     = gen_r;
    grid_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_go_s) begin
          state_n = SEED;
          presc_n = DIV_ZERO;
          gen_n   = GEN_ZERO;
        end else begin
          state_n = IDLE;
        end
      end
      SEED: begin
        if (bus.load) begin
          state_n = RUN;
        end else begin
          state_n = SEED;
        end
      end
      RUN: begin
        if (start_go_s) begin
          state_n = SEED;
          presc_n = DIV_ZERO;
          gen_n   = GEN_ZERO;
        end else begin
          if (over_s) begin
            presc_n = DIV_ZERO;
          end else if (tick_s) begin
            presc_n   = DIV_ZERO;
            grid_en_s = 1'b1;
            gen_n     = gen_inc_s;
          end else begin
            presc_n = presc_r + DIV_ONE;
          end
          // A pulse that reaches the limit wins over a pause request.
          if (tick_s && hit_limit_s) begin
            state_n = DONE;
          end else if (rise_pause_s) begin
            state_n = PAUSE;
          end else begin
            state_n = RUN;
          end
        end
      end
      PAUSE: begin
        if (start_go_s) begin
          state_n = SEED;
          presc_n = DIV_ZERO;
          gen_n   = GEN_ZERO;
        end else if (rise_pause_s) begin
          state_n = RUN;
        end else if (rise_step_s) begin
          grid_en_s = 1'b1;
          gen_n     = gen_inc_s;
          if (hit_limit_s) begin
            state_n = DONE;
          end else begin
            state_n = PAUSE;
          end
        end else begin
          state_n = PAUSE;
        end
      end
      DONE: begin
        if (start_go_s) begin
          state_n = SEED;
          presc_n = DIV_ZERO;
          gen_n   = GEN_ZERO;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, prescaler and generation counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      presc_r <= DIV_ZERO;
      gen_r   <= GEN_ZERO;
    end else begin
      state_r <= state_n;
      presc_r <= presc_n;
      gen_r   <= gen_n;
    end
  end

  // Level outputs decoded from the registered state; unknown codes look like IDLE.
  always_comb begin
    grid_rst_s = (state_r == IDLE) || !state_is_legal(state_r);
    seed_we_s  = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      SEED:    seed_we_s = 1'b1;
      DONE:    done_s    = 1'b1;
      default: begin
        seed_we_s = 1'b0;
        done_s    = 1'b0;
      end
    endcase
  end

  assign bus.grid_rst  = grid_rst_s;
  assign bus.seed_we   = seed_we_s;
  assign bus.grid_en   = grid_en_s;
  assign bus.gen_count = gen_r;
  assign bus.done      = done_s;
  assign bus.state_o   = state_r;

endmodule
